// File: rtl/bayer_demosaic_2x2_pkg.sv
// rtl/bayer_demosaic_2x2_pkg.sv - CFA pattern/colour types and per-position colour lookup
package raw2rgb_pkg;

    typedef enum logic [1:0] {
        GRBG = 2'd0,
        RGGB = 2'd1,
        BGGR = 2'd2,
        GBRG = 2'd3
    } bayer_pattern_e;

    typedef enum logic [1:0] {
        C_R = 2'd0,
        C_G = 2'd1,
        C_B = 2'd2
    } colour_e;

    // y0/x0 are the row/column parities of the sample.
    function automatic colour_e cfa_colour(bayer_pattern_e pattern, logic y0, logic x0);
        colour_e c;
        c = C_G;
        case (pattern)
            GRBG: case ({y0, x0}) 2'b01: c = C_R; 2'b10: c = C_B; default: c = C_G; endcase
            RGGB: case ({y0, x0}) 2'b00: c = C_R; 2'b11: c = C_B; default: c = C_G; endcase
            BGGR: case ({y0, x0}) 2'b00: c = C_B; 2'b11: c = C_R; default: c = C_G; endcase
            GBRG: case ({y0, x0}) 2'b01: c = C_B; 2'b10: c = C_R; default: c = C_G; endcase
            default: c = C_G;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/bayer_demosaic_2x2_if.sv
// rtl/bayer_demosaic_2x2_if.sv - raw pixel in / RGB pixel out bundle
interface bayer_demosaic_2x2_if #(
    parameter int DATA_W = 12,
    parameter int CONT_W = 11
);
    logic [CONT_W-1:0] iX_Cont;
    logic [CONT_W-1:0] iY_Cont;
    logic [DATA_W-1:0] iDATA;
    logic              iDVAL;
    logic              iBYPASS;
    logic [DATA_W-1:0] oRed;
    logic [DATA_W-1:0] oGreen;
    logic [DATA_W-1:0] oBlue;
    logic [CONT_W-1:0] oX_Cont;
    logic [CONT_W-1:0] oY_Cont;
    logic              oDVAL;

    modport slave (
        input  iX_Cont, iY_Cont, iDATA, iDVAL, iBYPASS,
        output oRed, oGreen, oBlue, oX_Cont, oY_Cont, oDVAL
    );

    modport master (
        output iX_Cont, iY_Cont, iDATA, iDVAL, iBYPASS,
        input  oRed, oGreen, oBlue, oX_Cont, oY_Cont, oDVAL
    );
endinterface

// File: rtl/raw_line_buffer.sv
// rtl/raw_line_buffer.sv - single-port read-before-write line RAM
module raw_line_buffer #(
    parameter int DEPTH  = 640,
    parameter int DATA_W = 12,
    parameter int AW     = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    // Read returns the word from the previous row before it is overwritten.
    always_ff @(posedge clk) begin
        if (we) begin
            rdata     <= mem[addr];
            mem[addr] <= wdata;
        end
    end
endmodule

// File: rtl/bayer_demosaic_2x2.sv
// rtl/bayer_demosaic_2x2.sv - 2x2-window Bayer demosaic with legacy bypass, 2-cycle latency
module bayer_demosaic_2x2
    import raw2rgb_pkg::*;
#(
    parameter int DATA_W    = 12,
    parameter int IMG_WIDTH = 640,
    parameter int CONT_W    = 11,
    parameter int PATTERN   = 0
) (
    input logic                 iCLK,
    input logic                 iRST,
    bayer_demosaic_2x2_if.slave bus
);
    localparam int                AW     = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [CONT_W-1:0] X_LAST = CONT_W'(IMG_WIDTH - 1);
    localparam logic [CONT_W-1:0] X_END  = CONT_W'(IMG_WIDTH);
    localparam bayer_pattern_e    PAT    = bayer_pattern_e'(2'(PATTERN));

    logic              in_range, lb_we, frame_start;
    logic [DATA_W-1:0] above;

    logic              row_valid_q, row_valid_d;
    logic              s1_valid_q, s1_valid_d, s1_byp_q, s1_byp_d;
    logic              s1_rv_q, s1_rv_d, s1_oob_q, s1_oob_d;
    logic [DATA_W-1:0] s1_data_q, s1_data_d;
    logic [CONT_W-1:0] s1_x_q, s1_x_d, s1_y_q, s1_y_d;
    logic [DATA_W-1:0] prev_cur_q, prev_cur_d, prev_a_q, prev_a_d;
    logic [DATA_W-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
    logic [CONT_W-1:0] ox_q, ox_d, oy_q, oy_d;
    logic              odval_q, odval_d;

    logic              col0, y0, x0;
    logic [DATA_W-1:0] a_eff;
    logic [DATA_W-1:0] win [4];
    colour_e           c11, c10, c01, c00;
    colour_e           wc [4];
    logic [DATA_W-1:0] r_sel, b_sel, g_first, g_last;
    logic              have_g;
    logic [DATA_W:0]   g_sum;

    assign in_range    = (bus.iX_Cont < X_END);
    assign lb_we       = bus.iDVAL && in_range;
    assign frame_start = bus.iDVAL && (bus.iX_Cont == '0) && (bus.iY_Cont == '0);

    raw_line_buffer #(
        .DEPTH (IMG_WIDTH),
        .DATA_W(DATA_W),
        .AW    (AW)
    ) u_line_buffer (
        .clk  (iCLK),
        .we   (lb_we),
        .addr (bus.iX_Cont[AW-1:0]),
        .wdata(bus.iDATA),
        .rdata(above)
    );

    always_comb begin
        row_valid_d = row_valid_q;
        if (frame_start)                          row_valid_d = 1'b0;
        if (bus.iDVAL && bus.iX_Cont == X_LAST)   row_valid_d = 1'b1;
        s1_valid_d = bus.iDVAL;
        s1_data_d  = s1_data_q;
        s1_x_d     = s1_x_q;
        s1_y_d     = s1_y_q;
        s1_byp_d   = s1_byp_q;
        s1_rv_d    = s1_rv_q;
        s1_oob_d   = s1_oob_q;
        if (bus.iDVAL) begin
            s1_data_d = bus.iDATA;
            s1_x_d    = bus.iX_Cont;
            s1_y_d    = bus.iY_Cont;
            s1_byp_d  = bus.iBYPASS;
            s1_rv_d   = row_valid_q && !frame_start;
            s1_oob_d  = !in_range;
        end
    end

    // Replicated window pixels inherit the colour of the sample they copy.
    always_comb begin
        col0  = (s1_x_q == '0);
        y0    = s1_y_q[0];
        x0    = s1_x_q[0];
        a_eff = s1_rv_q ? above : s1_data_q;
        c11   = cfa_colour(PAT, y0, x0);
        c10   = col0 ? c11 : cfa_colour(PAT, y0, ~x0);
        c01   = s1_rv_q ? cfa_colour(PAT, ~y0, x0) : c11;
        c00   = col0 ? c01 : (s1_rv_q ? cfa_colour(PAT, ~y0, ~x0) : c10);
        win[0] = s1_data_q;
        win[1] = col0 ? s1_data_q : prev_cur_q;
        win[2] = a_eff;
        win[3] = col0 ? a_eff : prev_a_q;
        wc[0] = c11;
        wc[1] = c10;
        wc[2] = c01;
        wc[3] = c00;
    end

    always_comb begin
        r_sel   = '0;
        b_sel   = '0;
        g_first = '0;
        g_last  = '0;
        have_g  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (wc[i] == C_R) r_sel = win[i];
            if (wc[i] == C_B) b_sel = win[i];
            if (wc[i] == C_G) begin
                if (!have_g) g_first = win[i];
                have_g = 1'b1;
                g_last = win[i];
            end
        end
        g_sum = {1'b0, g_first} + {1'b0, g_last};
    end

    always_comb begin
        red_d      = red_q;
        green_d    = green_q;
        blue_d     = blue_q;
        ox_d       = ox_q;
        oy_d       = oy_q;
        odval_d    = s1_valid_q;
        prev_cur_d = prev_cur_q;
        prev_a_d   = prev_a_q;
        if (s1_valid_q) begin
            ox_d    = s1_x_q;
            oy_d    = s1_y_q;
            red_d   = '0;
            green_d = '0;
            blue_d  = '0;
            if (!s1_oob_q) begin
                prev_cur_d = s1_data_q;
                prev_a_d   = a_eff;
                if (s1_byp_q) begin
                    case (c11)
                        C_R:     red_d   = s1_data_q;
                        C_B:     blue_d  = s1_data_q;
                        default: green_d = s1_data_q;
                    endcase
                end else begin
                    red_d   = r_sel;
                    green_d = g_sum[DATA_W:1];
                    blue_d  = b_sel;
                end
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            row_valid_q <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_x_q      <= '0;
            s1_y_q      <= '0;
            s1_byp_q    <= 1'b0;
            s1_rv_q     <= 1'b0;
            s1_oob_q    <= 1'b0;
            prev_cur_q  <= '0;
            prev_a_q    <= '0;
            red_q       <= '0;
            green_q     <= '0;
            blue_q      <= '0;
            ox_q        <= '0;
            oy_q        <= '0;
            odval_q     <= 1'b0;
        end else begin
            row_valid_q <= row_valid_d;
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s1_x_q      <= s1_x_d;
            s1_y_q      <= s1_y_d;
            s1_byp_q    <= s1_byp_d;
            s1_rv_q     <= s1_rv_d;
            s1_oob_q    <= s1_oob_d;
            prev_cur_q  <= prev_cur_d;
            prev_a_q    <= prev_a_d;
            red_q       <= red_d;
            green_q     <= green_d;
            blue_q      <= blue_d;
            ox_q        <= ox_d;
            oy_q        <= oy_d;
            odval_q     <= odval_d;
        end
    end

    assign bus.oRed    = red_q;
    assign bus.oGreen  = green_q;
    assign bus.oBlue   = blue_q;
    assign bus.oX_Cont = ox_q;
    assign bus.oY_Cont = oy_q;
    assign bus.oDVAL   = odval_q;
endmodule

// File: tb/tb_bayer_demosaic_2x2.sv
// tb/tb_bayer_demosaic_2x2.sv - vector table plus random scoreboard for two CFA phases
module tb_bayer_demosaic_2x2;
    localparam int DW = 12;
    localparam int CW = 11;
    localparam int W  = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bayer_demosaic_2x2_if #(.DATA_W(DW), .CONT_W(CW)) bus0 ();
    bayer_demosaic_2x2_if #(.DATA_W(DW), .CONT_W(CW)) bus1 ();

    bayer_demosaic_2x2 #(.DATA_W(DW), .IMG_WIDTH(W), .CONT_W(CW), .PATTERN(0))
        dut0 (.iCLK(clk), .iRST(rst_n), .bus(bus0));
    bayer_demosaic_2x2 #(.DATA_W(DW), .IMG_WIDTH(W), .CONT_W(CW), .PATTERN(1))
        dut1 (.iCLK(clk), .iRST(rst_n), .bus(bus1));

    typedef struct {
        logic [DW-1:0] r, g, b;
        logic [CW-1:0] x, y;
        bit            oob;
    } exp_t;

    typedef struct {
        bit dv; int x; int y; logic [DW-1:0] d; bit byp;
        bit chk; int inst; logic [DW-1:0] r, g, b;
    } vec_t;

    exp_t          q0[$], q1[$];
    vec_t          tab[$];
    logic [DW-1:0] pix [0:15][0:W-1];
    bit            rv, dv1, dv2;
    int            n_tests = 0;
    int            n_fail  = 0;

    function automatic byte colour_of(int pat, int y, int x);
        string s;
        case (pat)
            0: s = "GRBG";
            1: s = "RGGB";
            2: s = "BGGR";
            default: s = "GBRG";
        endcase
        return s[(y % 2) * 2 + (x % 2)];
    endfunction

    // Window sources by image position; a replicated source keeps its own position.
    function automatic exp_t model(int pat, int y, int x, logic [DW-1:0] d, bit byp, bit rvb);
        int sy[4], sx[4];
        logic [DW-1:0] sv[4];
        exp_t e;
        int gs, gc;
        byte c;
        e.r = '0; e.g = '0; e.b = '0; e.x = CW'(x); e.y = CW'(y); e.oob = (x >= W);
        if (e.oob) return e;
        sy[0] = y; sx[0] = x; sv[0] = d;
        if (x == 0) begin sy[1] = sy[0]; sx[1] = sx[0]; sv[1] = sv[0]; end
        else begin sy[1] = y; sx[1] = x - 1; sv[1] = pix[y][x-1]; end
        if (rvb && y > 0) begin sy[2] = y - 1; sx[2] = x; sv[2] = pix[y-1][x]; end
        else begin sy[2] = sy[0]; sx[2] = sx[0]; sv[2] = sv[0]; end
        if (x == 0) begin sy[3] = sy[2]; sx[3] = sx[2]; sv[3] = sv[2]; end
        else if (rvb && y > 0) begin sy[3] = y - 1; sx[3] = x - 1; sv[3] = pix[y-1][x-1]; end
        else begin sy[3] = sy[1]; sx[3] = sx[1]; sv[3] = sv[1]; end
        if (byp) begin
            c = colour_of(pat, y, x);
            if (c == "R") e.r = d; else if (c == "B") e.b = d; else e.g = d;
            return e;
        end
        gs = 0; gc = 0;
        for (int i = 0; i < 4; i++) begin
            c = colour_of(pat, sy[i], sx[i]);
            if (c == "R") e.r = sv[i];
            else if (c == "B") e.b = sv[i];
            else begin gs += int'(sv[i]); gc++; end
        end
        if (gc > 0) e.g = DW'(gs / gc);
        return e;
    endfunction

    task automatic check_inst(int inst, logic odv, logic [DW-1:0] r, g, b, logic [CW-1:0] x, y);
        exp_t e;
        n_tests++;
        if (odv !== dv2) begin
            n_fail++;
            $display("FAIL dval inst%0d got %0b want %0b at %0t", inst, odv, dv2, $time);
        end
        if (dv2) begin
            n_tests++;
            if ((inst == 0 && q0.size() == 0) || (inst == 1 && q1.size() == 0)) begin
                n_fail++;
                $display("FAIL sb_empty inst%0d got empty queue want entry", inst);
            end else begin
                e = (inst == 0) ? q0.pop_front() : q1.pop_front();
                if ({r, g, b} !== {e.r, e.g, e.b} || (!e.oob && {x, y} !== {e.x, e.y})) begin
                    n_fail++;
                    $display("FAIL pix inst%0d got rgb=%h/%h/%h xy=%0d,%0d want rgb=%h/%h/%h xy=%0d,%0d",
                             inst, r, g, b, x, y, e.r, e.g, e.b, e.x, e.y);
                end
            end
        end
    endtask

    task automatic cycle(bit dv, int x, int y, logic [DW-1:0] d, bit byp);
        bit rvb;
        @(negedge clk);
        check_inst(0, bus0.oDVAL, bus0.oRed, bus0.oGreen, bus0.oBlue, bus0.oX_Cont, bus0.oY_Cont);
        check_inst(1, bus1.oDVAL, bus1.oRed, bus1.oGreen, bus1.oBlue, bus1.oX_Cont, bus1.oY_Cont);
        dv2 = dv1;
        dv1 = dv;
        bus0.iDVAL = dv; bus0.iX_Cont = CW'(x); bus0.iY_Cont = CW'(y); bus0.iDATA = d; bus0.iBYPASS = byp;
        bus1.iDVAL = dv; bus1.iX_Cont = CW'(x); bus1.iY_Cont = CW'(y); bus1.iDATA = d; bus1.iBYPASS = byp;
        if (dv) begin
            rvb = rv && !(x == 0 && y == 0);
            q0.push_back(model(0, y, x, d, byp, rvb));
            q1.push_back(model(1, y, x, d, byp, rvb));
            if (x < W) pix[y][x] = d;
            if (x == 0 && y == 0) rv = 1'b0;
            if (x == W - 1) rv = 1'b1;
        end
    endtask

    task automatic cmp_rgb(string name, int inst, logic [DW-1:0] er, eg, eb);
        logic [3*DW-1:0] got;
        got = (inst == 0) ? {bus0.oRed, bus0.oGreen, bus0.oBlue} : {bus1.oRed, bus1.oGreen, bus1.oBlue};
        n_tests++;
        if (got !== {er, eg, eb}) begin
            n_fail++;
            $display("FAIL %s inst%0d got %h want %h", name, inst, got, {er, eg, eb});
        end
    endtask

    task automatic cmp_zero(string name);
        n_tests++;
        if ({bus0.oDVAL, bus0.oRed, bus0.oGreen, bus0.oBlue, bus0.oX_Cont, bus0.oY_Cont,
             bus1.oDVAL, bus1.oRed, bus1.oGreen, bus1.oBlue, bus1.oX_Cont, bus1.oY_Cont} !== '0) begin
            n_fail++;
            $display("FAIL %s got rgb0=%h/%h/%h dv0=%0b rgb1=%h/%h/%h dv1=%0b want all zero", name,
                     bus0.oRed, bus0.oGreen, bus0.oBlue, bus0.oDVAL,
                     bus1.oRed, bus1.oGreen, bus1.oBlue, bus1.oDVAL);
        end
    endtask

    function automatic vec_t mk(bit dv, int x, int y, int d, bit byp, bit chk, int inst, int r, int g, int b);
        vec_t v;
        v.dv = dv; v.x = x; v.y = y; v.d = DW'(d); v.byp = byp;
        v.chk = chk; v.inst = inst; v.r = DW'(r); v.g = DW'(g); v.b = DW'(b);
        return v;
    endfunction

    initial begin
        byte c;
        int  fd;
        // Green averaging, PATTERN 0: windows at (1,1) and (1,3) each hold two greens.
        tab.push_back(mk(1,0,0,'hFFF,0,0,0,0,0,0)); tab.push_back(mk(1,1,0,'h111,0,0,0,0,0,0));
        tab.push_back(mk(1,2,0,'h001,0,0,0,0,0,0)); tab.push_back(mk(1,3,0,'h222,0,0,0,0,0,0));
        tab.push_back(mk(1,0,1,'h333,0,0,0,0,0,0)); tab.push_back(mk(1,1,1,'hFFE,0,1,0,'h111,'hFFE,'h333));
        tab.push_back(mk(1,2,1,'h444,0,0,0,0,0,0)); tab.push_back(mk(1,3,1,'h000,0,1,0,'h222,'h000,'h444));
        // First row of a frame, PATTERN 1: no third colour available.
        tab.push_back(mk(1,0,0,'h100,0,0,1,0,0,0));     tab.push_back(mk(1,1,0,'h200,0,1,1,'h100,'h200,0));
        tab.push_back(mk(1,2,0,'h100,0,1,1,'h100,'h200,0)); tab.push_back(mk(1,3,0,'h200,0,1,1,'h100,'h200,0));
        // Bypass 2x2 frame, PATTERN 0.
        tab.push_back(mk(1,0,0,'h10,1,1,0,0,'h10,0)); tab.push_back(mk(1,1,0,'h20,1,1,0,'h20,0,0));
        tab.push_back(mk(1,0,1,'h30,1,1,0,0,0,'h30)); tab.push_back(mk(1,1,1,'h40,1,1,0,0,'h40,0));
        // Flat field, PATTERN 0.
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < W; x++) begin
                c  = colour_of(0, y, x);
                fd = (c == "R") ? 'h400 : (c == "G") ? 'h800 : 'hC00;
                tab.push_back(mk(1, x, y, fd, 0, (y >= 1 && x >= 1), 0, 'h400, 'h800, 'hC00));
            end
        end
        // iDVAL gaps 1,0,0,1,1,0,1 within one row, then an out-of-range column.
        tab.push_back(mk(1,0,0,'h123,0,0,0,0,0,0)); tab.push_back(mk(0,0,0,0,0,0,0,0,0,0));
        tab.push_back(mk(0,0,0,0,0,0,0,0,0,0));     tab.push_back(mk(1,1,0,'h456,0,0,0,0,0,0));
        tab.push_back(mk(1,2,0,'h789,0,0,0,0,0,0)); tab.push_back(mk(0,0,0,0,0,0,0,0,0,0));
        tab.push_back(mk(1,3,0,'hABC,0,0,0,0,0,0)); tab.push_back(mk(1,6,0,'h5A5,0,1,0,0,0,0));

        rv = 1'b0; dv1 = 1'b0; dv2 = 1'b0;
        bus0.iDVAL = 0; bus0.iX_Cont = '0; bus0.iY_Cont = '0; bus0.iDATA = '0; bus0.iBYPASS = 0;
        bus1.iDVAL = 0; bus1.iX_Cont = '0; bus1.iY_Cont = '0; bus1.iDATA = '0; bus1.iBYPASS = 0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        cmp_zero("reset_state");
        #1 rst_n = 1'b1;

        for (int i = 0; i < tab.size() + 2; i++) begin
            if (i < tab.size()) cycle(tab[i].dv, tab[i].x, tab[i].y, tab[i].d, tab[i].byp);
            else cycle(0, 0, 0, '0, 0);
            if (i >= 2 && tab[i-2].dv && tab[i-2].chk)
                cmp_rgb($sformatf("vec%0d", i - 2), tab[i-2].inst, tab[i-2].r, tab[i-2].g, tab[i-2].b);
        end

        // Mid-row reset in row 2, resume at row 3 with vertical replication.
        for (int y = 0; y < 2; y++)
            for (int x = 0; x < W; x++) cycle(1, x, y, DW'($urandom), 0);
        cycle(1, 0, 2, DW'($urandom), 0);
        cycle(1, 1, 2, DW'($urandom), 0);
        cycle(0, 0, 0, '0, 0);
        #2 rst_n = 1'b0;
        #1 cmp_zero("async_reset");
        q0.delete(); q1.delete();
        dv1 = 1'b0; dv2 = 1'b0; rv = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        cycle(0, 0, 0, '0, 0);
        for (int y = 3; y < 5; y++)
            for (int x = 0; x < W; x++) cycle(1, x, y, DW'($urandom), 0);

        // Random frames with gaps and per-pixel bypass toggling.
        for (int f = 0; f < 4; f++) begin
            for (int y = 0; y < 5; y++) begin
                for (int x = 0; x < W; x++) begin
                    while ($urandom_range(3) == 0) cycle(0, 0, 0, '0, 0);
                    cycle(1, x, y, DW'($urandom), ($urandom_range(4) == 0));
                end
            end
        end
        repeat (3) cycle(0, 0, 0, '0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/bayer_demosaic_2x2.md
Name: bayer_demosaic_2x2

Overview:
- Parametrised successor to the per-pixel Bayer channel splitter. Reconstructs full RGB at every pixel from the raw CCD stream using a 2x2 window: current and previous pixel of this row, plus the same two columns of the previous row, held in a one-line buffer.
- Sits between the CCD capture counter block and the colour-threshold/tracking logic.
- Supports a runtime bypass mode that reproduces the legacy masked-channel output with identical latency.

Parameters:
- DATA_W, 12, raw and per-channel pixel width.
- IMG_WIDTH, 640, active pixels per row; line buffer depth.
- CONT_W, 11, width of X/Y counters.
- PATTERN, 0, CFA colour at (even row, even col) phase: 0=GRBG, 1=RGGB, 2=BGGR, 3=GBRG.

Ports:
- iCLK  in  1  pixel clock.
- iRST  in  1  asynchronous, active-low reset.
- iX_Cont  in  CONT_W  column of iDATA, 0..IMG_WIDTH-1.
- iY_Cont  in  CONT_W  row of iDATA.
- iDATA  in  DATA_W  raw Bayer sample.
- iDVAL  in  1  iDATA/counters valid this cycle.
- iBYPASS  in  1  1 = legacy masked output (no interpolation).
- oRed  out  DATA_W  red.
- oGreen  out  DATA_W  green.
- oBlue  out  DATA_W  blue.
- oX_Cont  out  CONT_W  column of the output pixel.
- oY_Cont  out  CONT_W  row of the output pixel.
- oDVAL  out  1  outputs valid.

Behaviour:
- Clock and reset: one clock, iCLK; reset iRST is asynchronous and active-low.
- Reset values: all outputs and pipeline registers 0; row_valid=0. Line buffer RAM contents are not reset.
- Latency:
  - Fixed 2 cycles: iDVAL high in cycle N gives oDVAL high in cycle N+2.
  - Gaps in iDVAL are reproduced exactly on oDVAL.
  - The pipeline advances every cycle; no backpressure.
- Stage 1 (on iDVAL):
  - Synchronous line-buffer read and write at address iX_Cont. Read returns the old word: the above pixel A.
  - Write iDATA.
  - Register iDATA, iX_Cont, iY_Cont, iBYPASS and the valid bit.
- Stage 2 (on stage-1 valid):
  - Window: P11=cur, P01=A. P10 and P00 are the previous valid cur and A, held from the last valid stage-1 beat.
  - Output registers load on valid only. oDVAL follows valid every cycle.
- Colour assignment:
  - Each window pixel's colour is derived from its own (row parity, col parity) plus PATTERN.
  - Any 2x2 window contains exactly one R, one B and two G.
  - oRed = R sample; oBlue = B sample.
  - oGreen = (G_a + G_b) >> 1, with the sum computed at DATA_W+1 bits (no overflow, truncating).
- Boundaries:
  - Column 0: P10=P11 and P00=P01 (horizontal replication). P10/P00 are never taken from the previous row's last pixel.
  - Row with row_valid=0 (first row after reset): A is replaced by cur, i.e. vertical replication. The window then holds a single row's 2 colours; the missing colour is output as 0.
  - row_valid sets on the valid beat with iX_Cont==IMG_WIDTH-1.
  - row_valid clears on reset, or when iY_Cont==0 and iX_Cont==0 with iDVAL (frame start).
- iX_Cont >= IMG_WIDTH with iDVAL: no RAM write, beat passes with oDVAL=1 and outputs 0.
- Bypass (stage-2 registered iBYPASS):
  - Output the single channel matching P11's colour = P11; other channels 0.
  - Counters and latency are unchanged.
  - Toggling mid-row takes effect per pixel.
- Coordinates: oX_Cont/oY_Cont equal the counters of P11, delayed 2 cycles.
- Reset mid-row: pipeline flushes to 0 immediately; oDVAL is 0 from reset assertion until 2 cycles after the first post-release iDVAL.

Decomposition:
- Package raw2rgb_pkg:
  - bayer_pattern_e enum (GRBG, RGGB, BGGR, GBRG).
  - colour_e enum (C_R, C_G, C_B).
  - Function cfa_colour(pattern, y0, x0) returning colour_e.
- Sub-module raw_line_buffer: single-port synchronous RAM, DEPTH=IMG_WIDTH, width DATA_W, read-before-write, write enable, inferred block RAM.

Test Plan:
- PATTERN=0, flat field with G=0x800, R=0x400, B=0xC00, 4x4 frame continuous iDVAL. From row 1 col 1 on, every output is R=0x400, G=0x800, B=0xC00; oDVAL is 2 cycles after iDVAL.
- Green averaging: G1=0xFFF, G2=0xFFE -> oGreen=0xFFE (no wrap). G1=0x001, G2=0x000 -> 0x000.
- First row after reset, PATTERN=1: row 0 = R 0x100, G 0x200 alternating. Outputs R=0x100, G=0x200, B=0 throughout; column 0 replicated.
- iBYPASS=1, PATTERN=0, 2x2 frame {0x10, 0x20; 0x30, 0x40}. Output sequence (G=0x10), (R=0x20), (B=0x30), (G=0x40), each with other channels 0.
- iDVAL pattern 1,0,0,1,1,0,1 within a row: oDVAL is the same pattern shifted 2 cycles. Window neighbours come from the previous valid beat, not the gap.
- Assert iRST mid-row 2 for 1 cycle: outputs 0 asynchronously. Resume at row 3: the first row is treated as row_valid=0 (vertical replication) until a full row completes.
